// File: rtl/vmem_pkg.sv
// Shared types and helpers for the vector memory unit.
// Holds the FSM state encoding, lane geometry and address mapping.
package vmem_pkg;

    localparam int VEC_W  = 128;
    localparam int WORD_W = 32;
    localparam int LANES  = VEC_W / WORD_W;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE,
        VBURST,
        DRAIN,
        RESP
    } state_t;

    // Byte address to word index; the mask wraps modulo a power-of-two depth.
    function automatic logic [31:0] word_index(
        input logic [31:0] addr,
        input int unsigned depth
    );
        return (addr >> 2) & (depth - 32'd1);
    endfunction

endpackage

// File: rtl/vmem_ram.sv
// Single-port synchronous word RAM.
// Read data follows the address by one cycle; contents survive reset.
module vmem_ram #(
    parameter int N     = 32,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [N-1:0]             wdata,
    output logic [N-1:0]             rdata
);

    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/vector_mem_unit.sv
// Memory-side responder for the vector load/store sequencer.
// Serves scalar and LANES-long vector bursts against a local word RAM.
module vector_mem_unit
    import vmem_pkg::*;
#(
    parameter int V     = VEC_W,
    parameter int N     = WORD_W,
    parameter int DEPTH = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    input  logic         req_vec,
    input  logic         req_we,
    input  logic [N-1:0] req_addr,
    input  logic [V-1:0] wdata_vec,
    output logic         rsp_valid,
    output logic [V-1:0] rsp_data,
    output logic         wr_done,
    output logic         busy,
    output logic         err
);

    localparam int L  = V / N;
    localparam int LW = (L > 1) ? $clog2(L) : 1;
    localparam int AW = $clog2(DEPTH);

    localparam logic [LW-1:0] LAST = LW'(L - 1);

    state_t state;
    state_t state_d;

    logic [LW-1:0] lane;
    logic [LW-1:0] lane_d;
    logic [LW-1:0] lane_sel;
    logic [LW-1:0] cap_idx;

    logic vec_q;
    logic vec_d;
    logic we_q;
    logic we_d;

    logic wr_done_d;
    logic err_d;
    logic rsp_valid_d;
    logic cap_en;
    logic cap_clr;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [N-1:0]  ram_wdata;
    logic [N-1:0]  ram_rdata;

    assign ram_addr  = AW'(word_index(32'(req_addr), DEPTH));
    assign ram_wdata = wdata_vec[lane_sel*N +: N];

    // Cycle 0 of a vector request is still IDLE, so busy looks at the request.
    assign busy = (state != IDLE) || (req_valid && req_vec);

    vmem_ram #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d     = state;
        lane_d      = lane;
        vec_d       = vec_q;
        we_d        = we_q;
        wr_done_d   = 1'b0;
        err_d       = 1'b0;
        rsp_valid_d = 1'b0;
        ram_we      = 1'b0;
        lane_sel    = lane;
        cap_en      = 1'b0;
        cap_clr     = 1'b0;
        cap_idx     = lane - LW'(1);

        unique case (state)
            IDLE, RESP: begin
                state_d = IDLE;
                if (req_valid) begin
                    vec_d    = req_vec;
                    we_d     = req_we;
                    lane_sel = '0;
                    ram_we   = req_we;
                    if (req_vec) begin
                        state_d = VBURST;
                        lane_d  = LW'(1);
                    end else if (req_we) begin
                        wr_done_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end

            VBURST: begin
                if (!req_valid) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    lane_d  = '0;
                end else begin
                    ram_we = we_q;
                    cap_en = !we_q;
                    if (lane == LAST) begin
                        lane_d = '0;
                        if (we_q) begin
                            wr_done_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        lane_d = lane + LW'(1);
                    end
                end
            end

            DRAIN: begin
                cap_en      = 1'b1;
                cap_clr     = !vec_q;
                cap_idx     = vec_q ? LAST : '0;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lane      <= '0;
            vec_q     <= 1'b0;
            we_q      <= 1'b0;
            wr_done   <= 1'b0;
            err       <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_d;
            lane      <= lane_d;
            vec_q     <= vec_d;
            we_q      <= we_d;
            wr_done   <= wr_done_d;
            err       <= err_d;
            rsp_valid <= rsp_valid_d;
        end
    end

    // Scalar results replace the whole vector so the upper lanes read zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_data <= '0;
        end else if (cap_en) begin
            if (cap_clr) begin
                rsp_data <= V'(ram_rdata);
            end else begin
                rsp_data[cap_idx*N +: N] <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vector_mem_unit.sv
// Directed and random checks of vector_mem_unit against a word-array model.
// Timing of every pulse is derived per request from the request kind.
module tb_vector_mem_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_vec;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [127:0] wdata_vec;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic         wr_done;
    logic         busy;
    logic         err;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem_m [256];

    vector_mem_unit #(
        .V     (128),
        .N     (32),
        .DEPTH (256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_vec   (req_vec),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .wdata_vec (wdata_vec),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .wr_done   (wr_done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic int idx(input logic [31:0] a);
        return int'((a >> 2) & 32'hFF);
    endfunction

    task automatic chk(
        input string        tag,
        input logic [127:0] obs,
        input logic [127:0] exp
    );
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req_valid = 1'b0;
        req_vec   = 1'($urandom);
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        wdata_vec = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " rsp_valid"}, 128'(rsp_valid), 128'd0);
        chk({tag, " rsp_data"}, rsp_data, 128'd0);
        chk({tag, " wr_done"}, 128'(wr_done), 128'd0);
        chk({tag, " busy"}, 128'(busy), 128'd0);
        chk({tag, " err"}, 128'(err), 128'd0);
    endtask

    // One request from its cycle 0; started skips a cycle 0 already driven,
    // chain drives the next request's cycle 0 into this request's last cycle.
    task automatic do_req(
        input string        name,
        input bit           vec,
        input bit           we,
        input logic [31:0]  base,
        input logic [127:0] wd,
        input int           drop,
        input bit           started,
        input bit           chain,
        input bit           cvec,
        input bit           cwe,
        input logic [31:0]  cbase,
        input logic [127:0] cwd
    );
        int           nl;
        bit           ab;
        int           wd_cyc;
        int           rv_cyc;
        int           er_cyc;
        int           last;
        int           bf;
        int           bl;
        logic [127:0] exp_rsp;
        bit           exp_busy;
        string        t;

        nl      = vec ? 4 : 1;
        ab      = vec && (drop > 0);
        exp_rsp = '0;
        for (int k = 0; k < nl; k++) begin
            if (!we) begin
                exp_rsp[32*k +: 32] = mem_m[idx(base + 32'(4*k))];
            end else if (!ab || k < drop) begin
                mem_m[idx(base + 32'(4*k))] = wd[32*k +: 32];
            end
        end

        wd_cyc = (we && !ab) ? (vec ? 4 : 1) : -1;
        rv_cyc = (!we && !ab) ? (vec ? 5 : 2) : -1;
        er_cyc = ab ? drop + 1 : -1;
        if (ab) last = drop + 1;
        else last = we ? (vec ? 4 : 1) : (vec ? 5 : 2);
        bf = vec ? 0 : 1;
        if (vec) bl = ab ? drop : (we ? 3 : 5);
        else bl = we ? -1 : 2;

        for (int c = 0; c <= last; c++) begin
            if (!(c == 0 && started)) begin
                if (c < nl && !(ab && c >= drop)) begin
                    req_valid = 1'b1;
                    req_vec   = (c == 0) ? vec : 1'($urandom);
                    req_we    = (c == 0) ? we : 1'($urandom);
                    req_addr  = base + 32'(4*c);
                    wdata_vec = wd;
                end else if (chain && c == last) begin
                    req_valid = 1'b1;
                    req_vec   = cvec;
                    req_we    = cwe;
                    req_addr  = cbase;
                    wdata_vec = cwd;
                end else begin
                    drive_idle();
                end
                exp_busy = (c >= bf && c <= bl) || (chain && c == last && cvec);
                @(negedge clk);
                t = $sformatf("%s c%0d", name, c);
                chk({t, " wr_done"}, 128'(wr_done), 128'(c == wd_cyc));
                chk({t, " rsp_valid"}, 128'(rsp_valid), 128'(c == rv_cyc));
                chk({t, " err"}, 128'(err), 128'(c == er_cyc));
                chk({t, " busy"}, 128'(busy), 128'(exp_busy));
                if (c == rv_cyc) begin
                    chk({t, " rsp_data"}, rsp_data, exp_rsp);
                end
                tick();
            end
        end
    endtask

    task automatic req(
        input string        name,
        input bit           vec,
        input bit           we,
        input logic [31:0]  base,
        input logic [127:0] wd,
        input int           drop
    );
        do_req(name, vec, we, base, wd, drop, 1'b0, 1'b0,
               1'b0, 1'b0, 32'd0, 128'd0);
    endtask

    logic [127:0] vdat;
    logic [127:0] rdat;
    bit           rv;
    bit           rw;
    int           rdrop;

    initial begin
        rst = 1'b0;
        drive_idle();
        repeat (3) tick();
        chk_quiet("reset");
        rst = 1'b1;
        tick();

        for (int i = 0; i < 256; i++) begin
            req("fill", 1'b0, 1'b1, 32'(4*i), {96'd0, $urandom}, -1);
        end

        vdat = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
        req("vst100", 1'b1, 1'b1, 32'h100, vdat, -1);
        req("vld100", 1'b1, 1'b0, 32'h100, 128'd0, -1);
        chk("vld100 direct", rsp_data, vdat);

        req("sst3fc", 1'b0, 1'b1, 32'h3FC, 128'h1234_5678, -1);
        req("sld7fc", 1'b0, 1'b0, 32'h7FC, 128'd0, -1);
        chk("sld7fc direct", rsp_data, 128'h1234_5678);

        req("sst100", 1'b0, 1'b1, 32'h100, 128'h0BAD_F00D, -1);
        req("sld101", 1'b0, 1'b0, 32'h101, 128'd0, -1);
        chk("sld101 direct", rsp_data, 128'h0BAD_F00D);

        req("vst200ab", 1'b1, 1'b1, 32'h200, {4{32'h5A5A_0000}}, 2);
        req("vld200", 1'b1, 1'b0, 32'h200, 128'd0, -1);

        do_req("b2b_a", 1'b1, 1'b0, 32'h100, 128'd0, -1, 1'b0, 1'b1,
               1'b1, 1'b0, 32'h200, 128'd0);
        do_req("b2b_b", 1'b1, 1'b0, 32'h200, 128'd0, -1, 1'b1, 1'b0,
               1'b0, 1'b0, 32'd0, 128'd0);

        req_valid = 1'b1;
        req_vec   = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h100;
        tick();
        req_addr  = 32'h104;
        tick();
        req_addr  = 32'h108;
        tick();
        req_valid = 1'b0;
        rst       = 1'b0;
        #1;
        chk_quiet("midrst");
        tick();
        tick();
        chk_quiet("midrst held");
        rst = 1'b1;
        tick();
        chk_quiet("midrst after");
        req("sld0", 1'b0, 1'b0, 32'h0, 128'd0, -1);

        repeat (80) begin
            rv    = 1'($urandom);
            rw    = 1'($urandom);
            rdat  = {$urandom, $urandom, $urandom, $urandom};
            rdrop = (rv && $urandom_range(0, 4) == 0) ?
                    int'($urandom_range(1, 3)) : -1;
            req("rnd", rv, rw, $urandom, rdat, rdrop);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vector_mem_unit.md
Name: vector_mem_unit

Overview:
- Data-memory-side responder for the vector load/store sequencer; it is the far end of the per-cycle address stream that the sequencer emits while the CPU is stalled.
- Serves both address kinds:
  - scalar: one address per access.
  - vector: LANES consecutive addresses, one per cycle, one per lane.
- Owns a word-addressed synchronous RAM.
- Loads: gathers returned words into a V-bit vector and presents it with a one-cycle valid pulse.
- Stores: scatters lane slices of the store vector into memory.

Parameters:
- V, 128, vector width in bits.
- N, 32, word / scalar width in bits; LANES = V/N (4).
- DEPTH, 256, RAM depth in N-bit words; power of two.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  1  address valid this cycle.
- req_vec  in  1  request is vector (1) or scalar (0); sampled at burst start.
- req_we  in  1  store (1) or load (0); sampled at burst start.
- req_addr  in  N  byte address for the current lane.
- wdata_vec  in  V  store data; lane k = bits [N*k+N-1 : N*k]; scalar store uses lane 0.
- rsp_valid  out  1  one-cycle pulse: load result valid.
- rsp_data  out  V  load result; held until the next rsp_valid.
- wr_done  out  1  one-cycle pulse: store completed.
- busy  out  1  high while a vector burst is in progress or load data is pending.
- err  out  1  one-cycle pulse: vector burst aborted.

Behaviour:
- Reset (rst=0, async): outputs rsp_valid=0, rsp_data=0, wr_done=0, busy=0, err=0. State=IDLE, lane counter=0. RAM contents are not cleared. Reset mid-burst discards the burst with no pulses.
- Addressing: word index = req_addr[log2(DEPTH)+1:2]. Bits [1:0] are ignored. Higher bits are ignored, so addresses wrap modulo DEPTH.
- RAM: write takes effect at the edge. Read data appears the cycle after the address.
- States: IDLE, VBURST, DRAIN, RESP.
- IDLE with req_valid=1 (cycle 0):
  - Latch req_vec and req_we. Issue lane-0 access.
  - Scalar store: write lane 0; wr_done=1 in cycle 1; stay IDLE.
  - Scalar load: go to DRAIN. rsp_data = {0, word} is registered at the end of cycle 1; rsp_valid=1 in cycle 2 (state RESP).
  - Vector: go to VBURST with lane=1.
- VBURST, cycle k = 1..LANES-1:
  - req_valid must be 1; access lane k.
  - Store: write wdata_vec lane-k slice at the edge.
  - Load: word for lane k-1 is captured into rsp_data lane k-1.
  - After lane LANES-1:
    - Store: wr_done=1 in cycle LANES; return to IDLE.
    - Load: go to DRAIN.
- DRAIN: capture the last lane into rsp_data; go to RESP.
- RESP: rsp_valid=1 for one cycle; go to IDLE.
  - Vector load: rsp_valid in cycle LANES+1 (5).
  - A new req_valid is accepted in RESP as a cycle-0 request.
- rsp_data is updated lane-wise during capture. Lanes are not guaranteed coherent until rsp_valid.
- busy: 1 in VBURST, DRAIN and RESP; combinationally 1 in cycle 0 of a vector request.
- Abort: req_valid=0 while in VBURST.
  - err=1 next cycle; return to IDLE; no rsp_valid, no wr_done.
  - Lanes already written stay written.
- Requests are ignored in DRAIN.
- req_we and req_vec are not re-sampled mid-burst.

Decomposition:
- Package vmem_pkg:
  - state enum {IDLE, VBURST, DRAIN, RESP}.
  - constants LANES = V/N and LANE_W = $clog2(LANES).
  - function computing word index from a byte address.
- Sub-module vmem_ram: single-port sync RAM, parameters N and DEPTH, ports clk/we/addr/wdata/rdata, no reset.
- vector_mem_unit holds the FSM, lane counter, lane mux/demux and response register.

Test Plan:
- Reset with rst=0 mid-vector-load (after lane 2) -> all outputs 0 immediately; after release, a scalar load of word 0 returns rsp_valid at cycle 2 of that request.
- Vector store, addresses 0x100, 0x104, 0x108, 0x10C, wdata_vec = 0xDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA -> wr_done in cycle 4, busy 1 in cycles 0-3. A following vector load of the same addresses gives rsp_valid in cycle 5 with rsp_data equal to the stored vector.
- Scalar store of 0x1234_5678 to 0x3FC, then scalar load from 0x7FC (wrap) -> rsp_valid cycle 2, rsp_data = 0x...0000_1234_5678 (upper lanes 0).
- Scalar load from 0x101 (misaligned) after a store to 0x100 -> same word returned.
- Vector store with req_valid dropped in cycle 2 -> err pulse in cycle 3, no wr_done; lanes 0-1 written, lanes 2-3 unchanged.
- Back-to-back: new vector load issued in the RESP cycle of the prior load -> second rsp_valid exactly 5 cycles later, first rsp_data correct at its pulse.
